layer3_out_pipe_stage: RTL
==========================

Name: layer3_out_pipe_stage

Overview:
- Registered valid/ready pipeline stage between the layer-3 neuron LUTs and the layer-4 input.
- Bit i of s_data is the 1-bit output of layer3_Ni; bit 0 carries layer3_N0.
- Uses a 2-entry skid buffer so that both s_ready and m_valid/m_data come straight from flops, breaking the combinational LUT chain between layers.
- Sustains full throughput: one transfer per clock when m_ready is held high.

Parameters:
- W, 8, number of layer-3 neurons, i.e. the width of the data vector.
- CNT_W, 16, width of the performance counters (used only when LAYER_PIPE_PERF_CNT_EN is defined).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all buffered entries.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  stage can accept a word; driven directly from a flop.
- s_data  in  W  packed layer-3 neuron outputs.
- m_valid  out  1  downstream word valid; driven directly from a flop.
- m_ready  in  1  downstream accepts the word.
- m_data  out  W  word presented to layer 4; driven directly from a flop.
- perf_xfer_cnt  out  CNT_W  output transfer count (LAYER_PIPE_PERF_CNT_EN only).
- perf_stall_cnt  out  CNT_W  stall-cycle count (LAYER_PIPE_PERF_CNT_EN only).

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=EMPTY, m_valid=0, s_ready=0, m_data=0, skid register=0, counters=0.
- Release from reset: s_ready rises on the first clk edge after rst_n deasserts.
- Transfer definitions: an input transfer occurs when s_valid&s_ready; an output transfer occurs when m_valid&m_ready.
- States:
  - EMPTY: m_valid=0, s_ready=1.
  - ONE: main register holds a word; m_valid=1, s_ready=1.
  - FULL: main and skid registers both hold a word; m_valid=1, s_ready=0.
- Transitions:
  - EMPTY + input transfer -> ONE; main <= s_data. Latency is 1 cycle from input transfer to m_valid.
  - ONE, input transfer and output transfer in the same cycle -> ONE; main <= s_data.
  - ONE, input transfer only -> FULL; skid <= s_data.
  - ONE, output transfer only -> EMPTY.
  - FULL + output transfer -> ONE; main <= skid. No input transfer is possible in FULL because s_ready=0.
  - Any other combination: hold state and data.
- Ordering: words leave in arrival order. No word is lost or duplicated.
- Stability: m_data and m_valid stay stable while m_valid=1 and m_ready=0.
- s_valid without s_ready: the stage ignores it. Upstream must hold the word until it is accepted; the stage does not check this.
- flush: has priority over every handshake in the same cycle. Next state=EMPTY, m_valid=0, s_ready=1. Any input transfer in the flush cycle is discarded. Data registers are not cleared.
- Reset mid-operation: all buffered words are dropped immediately (asynchronous clear). No output transfer is reported for those words.
- Width: m_data equals a captured s_data bit-for-bit. No transformation is applied.

Optional Feature:
- Macro: LAYER_PIPE_PERF_CNT_EN.
- When defined:
  - perf_xfer_cnt increments on every output transfer.
  - perf_stall_cnt increments on every cycle with m_valid=1 and m_ready=0.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - flush clears both counters; rst_n clears them asynchronously.
  - Counter outputs are registered.
- When undefined: the two perf ports and the counter logic are absent. The handshake behaviour is identical.

Test Plan:
- Reset and release: hold rst_n=0 for 3 cycles -> m_valid=0, s_ready=0, m_data=0. After release, s_ready=1 on the first edge.
- Single word: s_data=8'hA5 with s_valid for 1 cycle, m_ready=1 -> m_valid=1 with m_data=8'hA5 one cycle later; state returns to EMPTY the following cycle.
- Back-to-back streaming: 100 words 0..99 with s_valid and m_ready held at 1 -> one word out per cycle in order; s_ready never drops.
- Backpressure: m_ready=0, send 8'h01, 8'h02, 8'h03 -> s_ready=0 after 2 accepted words; 8'h03 is held upstream. Then m_ready=1 -> outputs 01, 02, 03 in order with no loss.
- Flush priority: state FULL, assert flush together with s_valid (8'hFF) and m_ready -> next cycle m_valid=0, s_ready=1; 8'hFF never appears on m_data.
- Counters (macro on): 5 stall cycles, then 4 transfers -> perf_stall_cnt=5, perf_xfer_cnt=4. With CNT_W=4 and 20 transfers -> perf_xfer_cnt saturates at 15.

Source files
------------

// File: rtl/layer3_out_pipe_stage.sv
// layer3_out_pipe_stage: registered valid/ready stage between the layer-3
// neuron LUTs and the layer-4 input. A 2-entry skid buffer (main + skid)
// lets s_ready, m_valid and m_data all come straight from flops while still
// sustaining one transfer per clock.
// Optional feature macro: LAYER_PIPE_PERF_CNT_EN (saturating transfer and
// stall counters on perf_xfer_cnt / perf_stall_cnt).
module layer3_out_pipe_stage #(
    parameter int unsigned W = 8
`ifdef LAYER_PIPE_PERF_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data
`ifdef LAYER_PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_xfer_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           s_ready_q, s_ready_d;
    logic           m_valid_q, m_valid_d;
    logic           in_xfer;
    logic           out_xfer;

    // Handshakes are qualified by the registered ready/valid, never by
    // anything combinational from the other side.
    assign in_xfer  = s_valid & s_ready_q;
    assign out_xfer = m_valid_q & m_ready;

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_data   = main_q;

    // Next-state and data-path selection; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_d  = s_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d  = s_data;
                    end else if (in_xfer) begin
                        state_d = ST_FULL;
                        skid_d  = s_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // Flag flops are loaded from the next state so they match the state
        // register on every cycle without decoding it combinationally.
        m_valid_d = (state_d != ST_EMPTY);
        s_ready_d = (state_d != ST_FULL);
    end

    // State, data and handshake flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

`ifdef LAYER_PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall;

    assign stall          = m_valid_q & ~m_ready;
    assign perf_xfer_cnt  = xfer_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

    // Saturating counter updates; flush zeroes both.
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            xfer_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (out_xfer && (xfer_cnt_q != '1)) begin
                xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
